// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment scanner.
// One digit is lit per refresh slot. New values are double-buffered through a
// shadow register and committed to the display registers only at the end of a
// frame, so a frame is always drawn from a single consistent value.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      lz_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // Output level that means "off" for each pin group.
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic                      tick;
  logic                      boundary;

  logic [4*NUM_DIGITS-1:0]   sh_value;
  logic [NUM_DIGITS-1:0]     sh_dp;
  logic [NUM_DIGITS-1:0]     sh_blank;
  logic                      pending;

  logic [4*NUM_DIGITS-1:0]   disp_value;
  logic [NUM_DIGITS-1:0]     disp_dp;
  logic [NUM_DIGITS-1:0]     disp_blank;

  logic [NUM_DIGITS-1:0]     sup;
  logic                      zero_run;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_blank;
  logic                      cur_sup;
  logic [NUM_DIGITS-1:0]     onehot;

  logic [6:0]                seg_hi;
  logic                      dp_hi;
  logic [NUM_DIGITS-1:0]     an_hi;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Refresh counter and digit index; idx steps once per refresh slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow capture: the last load before a frame boundary wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Display registers only change at the frame boundary; a load on that very
  // cycle bypasses the shadow so it is not delayed by a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (boundary) begin
      if (load) begin
        disp_value <= value;
        disp_dp    <= dp_in;
        disp_blank <= blank_in;
      end else if (pending) begin
        disp_value <= sh_value;
        disp_dp    <= sh_dp;
        disp_blank <= sh_blank;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  // Digit 0 is never suppressed so an all-zero value still reads "0".
  always_comb begin
    sup      = '0;
    zero_run = lz_en;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (disp_value[4*k +: 4] == 4'h0);
      sup[k]   = zero_run;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = disp_value[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = disp_blank[k];
        cur_sup   = sup[k];
        onehot[k] = 1'b1;
      end
    end
  end

  // Active-high drive for the current slot. Blank darkens everything; a
  // suppressed digit keeps its anode only when it must show a decimal point.
  always_comb begin
    seg_hi = 7'h00;
    dp_hi  = 1'b0;
    an_hi  = '0;
    if (!cur_blank) begin
      dp_hi = cur_dp;
      if (cur_sup) begin
        an_hi = cur_dp ? onehot : '0;
      end else begin
        seg_hi = hex7(cur_nib);
        an_hi  = onehot;
      end
    end
  end

  // Registered pin drive with polarity applied, plus the frame-end pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= {7{SEG_OFF}};
      dp         <= SEG_OFF;
      an         <= {NUM_DIGITS{AN_OFF}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_hi ^ {7{SEG_OFF}};
      dp         <= dp_hi ^ SEG_OFF;
      an         <= an_hi ^ {NUM_DIGITS{AN_OFF}};
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 4-cycle slots, active-low pins.
// A time-based reference model predicts every output cycle; a vector table
// and a few hand sequences pin down the documented display cases.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int FR = N * R;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state: t counts clock edges since reset release.
  logic [6:0]  hexseg [16];
  int          t;
  logic [15:0] m_val, sh_val;
  logic [3:0]  m_dp, m_bl, sh_dp, sh_bl;
  bit          m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [27:0] seg;   // {digit3..digit0}, 7 bits each, pin levels
    logic [3:0]  dpo;   // dp pin level per digit
    logic [15:0] an;    // {digit3..digit0}, 4 bits each, pin levels
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] an_seq [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_val  = '0; m_dp = '0; m_bl = '0;
    sh_val = '0; sh_dp = '0; sh_bl = '0;
    m_pend = 0;
    e_seg  = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
  endtask

  // One clock edge of the model: outputs follow the slot that was active
  // just before the edge; frames are FR cycles long counted from release.
  task automatic model_edge();
    int         k, nib;
    bit         sup;
    logic [6:0] s_hi;
    logic       d_hi;
    logic [3:0] a_hi;
    k    = (t / R) % N;
    nib  = int'((m_val >> (4 * k)) & 16'hF);
    sup  = lz_en && (k > 0) && ((m_val >> (4 * k)) == 16'h0);
    s_hi = 7'h00; d_hi = 1'b0; a_hi = 4'h0;
    if (!m_bl[k]) begin
      d_hi = m_dp[k];
      if (sup) a_hi = m_dp[k] ? 4'(1 << k) : 4'h0;
      else begin
        s_hi = hexseg[nib];
        a_hi = 4'(1 << k);
      end
    end
    e_seg = ~s_hi; e_dp = ~d_hi; e_an = ~a_hi;
    e_fd  = ((t % FR) == FR - 1);
    if (load) begin
      sh_val = value; sh_dp = dp_in; sh_bl = blank_in; m_pend = 1;
    end
    if (e_fd && m_pend) begin
      m_val = sh_val; m_dp = sh_dp; m_bl = sh_bl; m_pend = 0;
    end
    t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk($sformatf("model_t%0d", t - 1), 32'({seg, dp, an, frame_done}),
        32'({e_seg, e_dp, e_an, e_fd}));
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while ((t % FR) != ph && n < FR) begin
      step();
      n++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int id);
    int n = 0;
    value = v.value; dp_in = v.dp; blank_in = v.blank; lz_en = v.lz; load = 1'b1;
    step();
    load = 1'b0;
    while (frame_done !== 1'b1 && n < 2 * FR) begin
      step();
      n++;
    end
    chk($sformatf("vec%0d_frame_done", id), 32'(frame_done), 32'd1);
    if (frame_done !== 1'b1) return;
    for (int k = 0; k < N; k++) begin
      step();
      chk($sformatf("vec%0d_digit%0d", id, k), 32'({seg, dp, an}),
          32'({v.seg[7*k +: 7], v.dpo[k], v.an[4*k +: 4]}));
      repeat (R - 1) step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] two_exp [4];
    hexseg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    two_exp = '{7'h78, 7'h40, 7'h40, 7'h40};
    vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{16'h0050, 4'b1000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0111,
                {4'b0111, 4'b1111, 4'b1101, 4'b1110}};
    vecs[2] = '{16'h8421, 4'b0010, 4'b0010, 1'b0, {7'h00, 7'h19, 7'h7F, 7'h79}, 4'hF,
                {4'b0111, 4'b1011, 4'b1111, 4'b1110}};
    vecs[3] = '{16'hFFFF, 4'h0, 4'h0, 1'b0, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'hF,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[4] = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF,
                {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
    vecs[5] = '{16'h0100, 4'b0001, 4'h0, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1110,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110}};

    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    model_reset();
    #1;
    chk("reset_outputs", 32'({seg, dp, an, frame_done}), 32'({7'h7F, 1'b1, 4'hF, 1'b0}));
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Free-running scan after reset with no load.
    for (int s = 1; s <= 2 * FR; s++) begin
      step();
      if ((s - 1) % R == 0) begin
        chk($sformatf("idle_an_s%0d", s), 32'(an), 32'(an_seq[((s - 1) / R) % N]));
        chk($sformatf("idle_seg_s%0d", s), 32'(seg), 32'h40);
      end
      chk($sformatf("idle_fd_s%0d", s), 32'(frame_done), 32'((s % FR) == 0));
    end

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

    // Load exactly on the boundary beats an earlier pending load.
    lz_en = 1'b0; dp_in = '0; blank_in = '0;
    wait_phase(5);
    value = 16'h1234; load = 1'b1; step(); load = 1'b0;
    wait_phase(FR - 1);
    value = 16'hFFFF; load = 1'b1; step(); load = 1'b0;
    for (int k = 0; k < N; k++) begin
      step();
      chk($sformatf("bnd_load_d%0d", k), 32'({seg, an}), 32'({7'h0E, an_seq[k]}));
      repeat (R - 1) step();
    end

    // Two loads in one frame: only the second shows.
    wait_phase(2);
    value = 16'h3333; load = 1'b1; step(); load = 1'b0;
    wait_phase(9);
    value = 16'h0007; load = 1'b1; step(); load = 1'b0;
    wait_phase(FR - 1);
    step();
    for (int k = 0; k < N; k++) begin
      step();
      chk($sformatf("two_load_d%0d", k), 32'(seg), 32'(two_exp[k]));
      repeat (R - 1) step();
    end

    // Reset during slot 2 with a load pending.
    wait_phase(2);
    value = 16'h9999; load = 1'b1; step(); load = 1'b0;
    wait_phase(10);
    rst = 1'b1;
    #1;
    chk("async_reset_dark", 32'({seg, dp, an, frame_done}), 32'({7'h7F, 1'b1, 4'hF, 1'b0}));
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 2 * FR; s++) begin
      step();
      if (s == 1 || s == FR + 1)
        chk($sformatf("post_reset_d0_s%0d", s), 32'({seg, an}), 32'({7'h40, 4'b1110}));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      value    = 16'($urandom >> (4 * $urandom_range(0, 4)));
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      step();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display. It scans one digit at a time from a packed hex value, with per-digit decimal point, explicit blanking and optional leading-zero suppression. New values are double-buffered and applied only at frame boundaries so the display never tears. It sits between the datapath or status logic and the board display pins, replacing per-digit combinational hex decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active-low, 0 = active-high
AN_ACTIVE_LOW, 1, 1 = anode enables active-low, 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load  in  1  single-cycle strobe; captures value/dp_in/blank_in into shadow
value  in  4*NUM_DIGITS  packed hex digits; digit 0 = value[3:0] (least significant)
dp_in  in  NUM_DIGITS  decimal point request per digit
blank_in  in  NUM_DIGITS  force digit fully dark (segments and dp)
lz_en  in  1  leading-zero blanking enable (sampled live)
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when last digit slot ends

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All state is cleared on rst assertion, independent of clk.
- Reset values: refresh counter 0, digit index 0, shadow/display registers 0, pending 0; seg/dp all off, an all inactive, frame_done 0.
- Refresh counter cnt runs 0..REFRESH_DIV-1. tick = (cnt == REFRESH_DIV-1). On tick, cnt -> 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary = tick && idx == NUM_DIGITS-1. frame_done is registered and high for exactly the cycle after the boundary.
- load writes the shadow registers (value, dp_in, blank_in) and sets pending. A later load before the boundary overwrites the shadow: last write wins.
- At a frame boundary with pending or load set, the display registers take the shadow contents and pending clears. If load coincides with the boundary, the same-cycle inputs go straight to the display registers.
- The display registers never change mid-frame.
- Outputs are registered, with one cycle of latency from idx/display state. The first cycle after rst deasserts drives digit 0.
- an is one-hot at bit idx. It drops to all-inactive when the current digit is dark (blank or LZ-suppressed).
- Decode (active-high form; inverted when SEG_ACTIVE_LOW=1):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71
- Leading-zero blanking, when lz_en=1:
  - Digit k is suppressed if it and every higher digit hold 0.
  - Digit 0 is never suppressed, so the value 0 shows "0".
  - A suppressed digit still shows dp if its dp bit is set; in that case an stays active for that slot with segments off.
- blank_in has priority over everything: segments, dp and an are all inactive for that slot.
- Reset mid-frame: everything returns to the reset values immediately. The pending load is discarded and scanning restarts at digit 0.

Test Plan:
- Use NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low in every scenario unless stated.
- Reset release, no load: an cycles 1110,1101,1011,0111, each held 4 cycles; seg=7'h40 ("0") on every digit; frame_done pulses every 16 cycles.
- load value=16'h12AF mid-frame: display unchanged until the boundary. The next frame shows digit0 seg=7'h0E (F), digit1 7'h08 (A), digit2 7'h24 (2), digit3 7'h79 (1).
- lz_en=1, value=16'h0050, dp_in=4'b1000:
  - Digits 3 and 2 have segments off. Digit 3 has dp=0 and its an stays active; digit 2's an is inactive.
  - Digit 1 shows 7'h12 (5); digit 0 shows 7'h40 (0).
- blank_in=4'b0010, dp_in=4'b0010: slot 1 has an=1111, seg=7'h7F, dp=1. Other digits are unaffected.
- load pulsed on the exact boundary cycle with value=16'hFFFF: the next frame shows F on all digits. Two loads within one frame: only the second value appears.
- rst asserted during slot 2 with a pending load: outputs go dark asynchronously. After release, scanning restarts at digit 0 showing 16'h0000, and the pending value is never displayed.
